// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART frame transmitter
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   // 50 MHz system clock at 115200 baud
   localparam int DEFAULT_CLKS_PER_BIT = 434;

   // Zero-extended data leaves the XOR reduction unchanged, so one width serves all DATA_W.
   function automatic logic calc_parity(input logic [8:0] data, input logic odd);
      return odd ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO buffering words ahead of the UART shifter
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             CLK,
   input  logic             BTN_N,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (!BTN_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is left unreset; the pointers alone define what is valid.
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_frame_tx.sv
// rtl/uart_frame_tx.sv - buffered UART transmitter with configurable width, parity and stop bits
module uart_frame_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_W       = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16,
   localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              CLK,
   input  logic              BTN_N,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              tx_o,
   output logic              busy_o,
   output logic [CW-1:0]     count_o
);

   localparam int BAUD_W     = $clog2(CLKS_PER_BIT);
   localparam int BIT_W      = 4;
   localparam bit HAS_PARITY = (PARITY != int'(PAR_NONE));
   localparam bit ODD_PARITY = (PARITY == int'(PAR_ODD));

   if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
      $error("uart_frame_tx: DATA_W must be in 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_frame_tx: STOP_BITS must be 1 or 2");
   end
   if (PARITY < int'(PAR_NONE) || PARITY > int'(PAR_ODD)) begin : g_bad_parity
      $error("uart_frame_tx: PARITY must be 0, 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_frame_tx: FIFO_DEPTH must be a power of two >= 2");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_frame_tx: CLKS_PER_BIT must be >= 2");
   end

   tx_state_e         state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              par_q, par_d;
   logic              tx_q, line_d;
   logic              rdy_q;
   logic              baud_end;
   logic              load;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_data;

   uart_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .BTN_N     (BTN_N),
      .push      (valid_i && ready_o),
      .push_data (data_i),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (count_o)
   );

   assign ready_o = rdy_q && !fifo_full;
   assign busy_o  = (state_q != TX_IDLE);
   assign tx_o    = tx_q;

   always_ff @(posedge CLK) begin
      if (!BTN_N) begin
         state_q <= TX_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         tx_q    <= line_d;
         rdy_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      par_d    = par_q;
      load     = 1'b0;
      fifo_pop = 1'b0;
      baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
      baud_d   = baud_end ? '0 : baud_q + BAUD_W'(1);

      unique case (state_q)
         TX_IDLE: begin
            baud_d = '0;
            load   = !fifo_empty;
         end
         TX_START: begin
            if (baud_end) begin
               state_d = TX_DATA;
               bit_d   = '0;
            end
         end
         TX_DATA: begin
            if (baud_end) begin
               shreg_d = shreg_q >> 1;
               if (bit_q == BIT_W'(DATA_W - 1)) begin
                  bit_d   = '0;
                  state_d = HAS_PARITY ? TX_PARITY : TX_STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         TX_PARITY: begin
            if (baud_end) begin
               state_d = TX_STOP;
               bit_d   = '0;
            end
         end
         TX_STOP: begin
            // bit_q counts stop bits here so the baud counter keeps a single period
            if (baud_end) begin
               if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                  bit_d   = '0;
                  load    = !fifo_empty;
                  state_d = TX_IDLE;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase

      if (load) begin
         fifo_pop = 1'b1;
         shreg_d  = fifo_data;
         par_d    = calc_parity(9'(fifo_data), ODD_PARITY);
         state_d  = TX_START;
         baud_d   = '0;
         bit_d    = '0;
      end
   end

   // Line level follows the registered state, so the pin trails the FSM by one clock.
   always_comb begin
      line_d = 1'b1;
      unique case (state_q)
         TX_START:  line_d = 1'b0;
         TX_DATA:   line_d = shreg_q[0];
         TX_PARITY: line_d = par_q;
         default:   line_d = 1'b1;
      endcase
   end

endmodule
